// File: rtl/msp430_pkg.sv
// Shared encodings, state enum and micro-program entry type for the SP sequencer.
package msp430_pkg;

   localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFE0;

   localparam logic [1:0] SP_HOLD = 2'b00;
   localparam logic [1:0] SP_DEC  = 2'b01;
   localparam logic [1:0] SP_INC  = 2'b10;
   localparam logic [1:0] SP_LOAD = 2'b11;

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_CALL = 3'd1;
   localparam logic [2:0] OP_RET  = 3'd2;
   localparam logic [2:0] OP_RETI = 3'd3;
   localparam logic [2:0] OP_INT  = 3'd4;

   localparam logic [1:0] SRC_OPND = 2'b00;
   localparam logic [1:0] SRC_PC   = 2'b01;
   localparam logic [1:0] SRC_SR   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEC,
      ST_WR,
      ST_RD,
      ST_INC,
      ST_VEC,
      ST_ERR
   } sp_state_e;

   typedef struct packed {
      sp_state_e  state;
      logic [1:0] src;
      logic       ld_pc;
      logic       ld_sr;
      logic       last;
   } rom_entry_t;

   typedef struct packed {
      logic [1:0] mux;
      logic       mab;
      logic [1:0] src;
      logic       wr;
      logic       rd;
      logic       ld_pc;
      logic       ld_sr;
      logic       clr_gie;
      logic       done;
      logic       fault;
   } strobe_t;

   function automatic rom_entry_t mk_step(input sp_state_e st, input logic [1:0] src,
                                          input logic ld_pc, input logic ld_sr,
                                          input logic last);
      rom_entry_t e;
      e.state = st;
      e.src   = src;
      e.ld_pc = ld_pc;
      e.ld_sr = ld_sr;
      e.last  = last;
      return e;
   endfunction

endpackage

// File: rtl/sp_seq_if.sv
// Decoder-side request and SP-mux / memory / register-file strobe bundle.
interface sp_seq_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [3:0]  int_idx;
   logic [15:0] reg_SP_out;
   logic        op_ready;
   logic [1:0]  MUX_SP_SEL;
   logic        MAB_SEL;
   logic [15:0] vec_addr;
   logic [1:0]  MDB_SRC_SEL;
   logic        MEM_WR;
   logic        MEM_RD;
   logic        LD_PC;
   logic        LD_SR;
   logic        CLR_GIE;
   logic        done;
   logic        fault;

   modport master (
      output op_valid, op_code, int_idx, reg_SP_out,
      input  op_ready, MUX_SP_SEL, MAB_SEL, vec_addr, MDB_SRC_SEL,
             MEM_WR, MEM_RD, LD_PC, LD_SR, CLR_GIE, done, fault
   );

   modport slave (
      input  op_valid, op_code, int_idx, reg_SP_out,
      output op_ready, MUX_SP_SEL, MAB_SEL, vec_addr, MDB_SRC_SEL,
             MEM_WR, MEM_RD, LD_PC, LD_SR, CLR_GIE, done, fault
   );
endinterface

// File: rtl/sp_seq_rom.sv
// Micro-program table: (op, step) -> state, write source, load strobes, last flag.
// Purely combinational; out-of-range entries map to ERR.
module sp_seq_rom
   import msp430_pkg::*;
(
   input  logic [2:0] op,
   input  logic [2:0] step,
   output rom_entry_t ent
);

   always_comb begin
      ent = mk_step(ST_ERR, SRC_OPND, 1'b0, 1'b0, 1'b0);
      case (op)
         OP_PUSH: begin
            case (step)
               3'd0:    ent = mk_step(ST_DEC, SRC_OPND, 1'b0, 1'b0, 1'b0);
               3'd1:    ent = mk_step(ST_WR,  SRC_OPND, 1'b0, 1'b0, 1'b1);
               default: ;
            endcase
         end
         OP_CALL: begin
            case (step)
               3'd0:    ent = mk_step(ST_DEC, SRC_OPND, 1'b0, 1'b0, 1'b0);
               3'd1:    ent = mk_step(ST_WR,  SRC_PC,   1'b0, 1'b0, 1'b1);
               default: ;
            endcase
         end
         OP_RET: begin
            case (step)
               3'd0:    ent = mk_step(ST_RD,  SRC_OPND, 1'b1, 1'b0, 1'b0);
               3'd1:    ent = mk_step(ST_INC, SRC_OPND, 1'b0, 1'b0, 1'b1);
               default: ;
            endcase
         end
         OP_RETI: begin
            case (step)
               3'd0:    ent = mk_step(ST_RD,  SRC_OPND, 1'b0, 1'b1, 1'b0);
               3'd1:    ent = mk_step(ST_INC, SRC_OPND, 1'b0, 1'b0, 1'b0);
               3'd2:    ent = mk_step(ST_RD,  SRC_OPND, 1'b1, 1'b0, 1'b0);
               3'd3:    ent = mk_step(ST_INC, SRC_OPND, 1'b0, 1'b0, 1'b1);
               default: ;
            endcase
         end
         OP_INT: begin
            case (step)
               3'd0:    ent = mk_step(ST_DEC, SRC_OPND, 1'b0, 1'b0, 1'b0);
               3'd1:    ent = mk_step(ST_WR,  SRC_PC,   1'b0, 1'b0, 1'b0);
               3'd2:    ent = mk_step(ST_DEC, SRC_OPND, 1'b0, 1'b0, 1'b0);
               3'd3:    ent = mk_step(ST_WR,  SRC_SR,   1'b0, 1'b0, 1'b0);
               3'd4:    ent = mk_step(ST_VEC, SRC_OPND, 1'b0, 1'b0, 1'b1);
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sp_seq.sv
// Stack-pointer sequencer: one micro-step per cycle, done 2/2/2/4/5 cycles after accept.
// Single op in flight; op_ready only in IDLE, decoder holds op_valid until accepted.
module sp_seq
   import msp430_pkg::*;
#(
   parameter logic [15:0] STACK_LIMIT = 16'h0200,
   parameter logic [15:0] VEC_BASE    = VEC_BASE_DEFAULT
) (
   input logic     clk,
   input logic     rst_n,
   sp_seq_if.slave bus
);

   sp_state_e  state_q, state_nxt;
   logic [2:0] op_q;
   logic [2:0] step_q, step_nxt;
   logic [2:0] rom_op, rom_idx;
   logic [15:0] vec_q;
   rom_entry_t rom_ent;
   strobe_t    out_q, out_nxt;
   logic       idle, accept, sp_low;

   assign idle   = (state_q == ST_IDLE);
   assign accept = idle && bus.op_valid;

   // In IDLE the table is indexed by the incoming op so the first step is entered on the accept edge.
   assign rom_op  = idle ? bus.op_code : op_q;
   assign rom_idx = idle ? 3'd0 : step_q + 3'd1;

   // 17-bit compare so an SP near zero faults instead of wrapping past the limit.
   assign sp_low = ({1'b0, bus.reg_SP_out}) < ({1'b0, STACK_LIMIT} + 17'd2);

   sp_seq_rom u_rom (
      .op   (rom_op),
      .step (rom_idx),
      .ent  (rom_ent)
   );

   always_comb begin
      state_nxt = state_q;
      step_nxt  = step_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.op_valid) begin
               state_nxt = rom_ent.state;
               step_nxt  = 3'd0;
            end
         end
         ST_ERR: state_nxt = ST_IDLE;
         default: begin
            step_nxt  = rom_idx;
            state_nxt = out_q.done ? ST_IDLE : rom_ent.state;
         end
      endcase
      if (state_nxt == ST_DEC && sp_low) begin
         state_nxt = ST_ERR;
      end
   end

   // Strobes are decoded from the state being entered and registered, so they line up with it.
   always_comb begin
      out_nxt = '0;
      case (state_nxt)
         ST_DEC: out_nxt.mux = SP_DEC;
         ST_INC: out_nxt.mux = SP_INC;
         ST_WR: begin
            out_nxt.wr  = 1'b1;
            out_nxt.src = rom_ent.src;
         end
         ST_RD: begin
            out_nxt.rd    = 1'b1;
            out_nxt.ld_pc = rom_ent.ld_pc;
            out_nxt.ld_sr = rom_ent.ld_sr;
         end
         ST_VEC: begin
            out_nxt.mab     = 1'b1;
            out_nxt.rd      = 1'b1;
            out_nxt.ld_pc   = 1'b1;
            out_nxt.clr_gie = 1'b1;
         end
         ST_ERR:  out_nxt.fault = 1'b1;
         default: ;
      endcase
      if (state_nxt != ST_IDLE && state_nxt != ST_ERR) begin
         out_nxt.done = rom_ent.last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= 3'd0;
         op_q    <= 3'd0;
         vec_q   <= 16'd0;
         out_q   <= '0;
      end else begin
         state_q <= state_nxt;
         step_q  <= step_nxt;
         out_q   <= out_nxt;
         if (accept) begin
            op_q  <= bus.op_code;
            vec_q <= VEC_BASE + {11'd0, bus.int_idx, 1'b0};
         end
      end
   end

   assign bus.op_ready    = idle;
   assign bus.MUX_SP_SEL  = out_q.mux;
   assign bus.MAB_SEL     = out_q.mab;
   assign bus.vec_addr    = vec_q;
   assign bus.MDB_SRC_SEL = out_q.src;
   assign bus.MEM_WR      = out_q.wr;
   assign bus.MEM_RD      = out_q.rd;
   assign bus.LD_PC       = out_q.ld_pc;
   assign bus.LD_SR       = out_q.ld_sr;
   assign bus.CLR_GIE     = out_q.clr_gie;
   assign bus.done        = out_q.done;
   assign bus.fault       = out_q.fault;

endmodule

// File: tb/tb_sp_seq.sv
// Scoreboard bench for sp_seq: stimulus queues hand-computed micro-steps, a negedge monitor checks them.
module tb_sp_seq;
   import msp430_pkg::*;

   // Step vector: {mux[1:0], mab, src[1:0], wr, rd, ld_pc, ld_sr, clr_gie, done, fault}
   localparam logic [11:0] V_DEC        = 12'b01_0_00_0_0_0_0_0_0_0;
   localparam logic [11:0] V_INC        = 12'b10_0_00_0_0_0_0_0_0_0;
   localparam logic [11:0] V_INC_DN     = 12'b10_0_00_0_0_0_0_0_1_0;
   localparam logic [11:0] V_WR_OPND_DN = 12'b00_0_00_1_0_0_0_0_1_0;
   localparam logic [11:0] V_WR_PC      = 12'b00_0_01_1_0_0_0_0_0_0;
   localparam logic [11:0] V_WR_PC_DN   = 12'b00_0_01_1_0_0_0_0_1_0;
   localparam logic [11:0] V_WR_SR      = 12'b00_0_10_1_0_0_0_0_0_0;
   localparam logic [11:0] V_RD_SR      = 12'b00_0_00_0_1_0_1_0_0_0;
   localparam logic [11:0] V_RD_PC      = 12'b00_0_00_0_1_1_0_0_0_0;
   localparam logic [11:0] V_RD_PC_DN   = 12'b00_0_00_0_1_1_0_0_1_0;
   localparam logic [11:0] V_VEC_DN     = 12'b00_1_00_0_1_1_0_1_1_0;
   localparam logic [11:0] V_FAULT      = 12'b00_0_00_0_0_0_0_0_0_1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [11:0] v;
      logic [15:0] vec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cyc = 32'd0;
   logic [15:0] sp = 16'd0;
   logic [15:0] sp_ld_val = 16'd0;
   logic        sp_ld = 1'b0;
   logic [31:0] last_acc = 32'd0;
   logic [11:0] obs;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        exp_q[$];
   logic [11:0] plan[$];

   sp_seq_if bus ();

   sp_seq #(.STACK_LIMIT(16'h0200), .VEC_BASE(16'hFFE0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.reg_SP_out = sp;
   assign obs = {bus.MUX_SP_SEL, bus.MAB_SEL, bus.MDB_SRC_SEL, bus.MEM_WR, bus.MEM_RD,
                 bus.LD_PC, bus.LD_SR, bus.CLR_GIE, bus.done, bus.fault};

   // SP register as seen through the mux.
   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (sp_ld) sp <= sp_ld_val;
      else begin
         case (bus.MUX_SP_SEL)
            SP_DEC:  sp <= sp - 16'd2;
            SP_INC:  sp <= sp + 16'd2;
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && obs != 12'd0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_step", {52'd0, obs}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("step", {4'd0, cyc, obs, bus.vec_addr}, {4'd0, e});
         end
      end
   end

   task automatic set_sp(input logic [15:0] v);
      @(negedge clk);
      sp_ld_val = v;
      sp_ld = 1'b1;
      @(posedge clk);
      #1 sp_ld = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic [15:0] vec);
      logic got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.op_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("accept_wait", {63'd0, bus.op_ready}, 64'd1);
         return;
      end
      bus.op_valid = 1'b1;
      bus.op_code  = op;
      bus.int_idx  = idx;
      @(posedge clk);
      #1 bus.op_valid = 1'b0;
      last_acc = cyc;
      for (int k = 0; k < plan.size(); k++) begin
         exp_q.push_back({last_acc + 32'(k), plan[k], vec});
      end
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.op_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("drain", {32'(exp_q.size()), 31'd0, bus.op_ready}, {32'd0, 31'd0, 1'b1});
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] a;
      bus.op_valid = 1'b0;
      bus.op_code  = 3'd0;
      bus.int_idx  = 4'd0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {63'd0, bus.op_ready}, 64'd1);
      chk("reset_outputs", {36'd0, obs, bus.vec_addr}, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      set_sp(16'h0400);
      plan = '{V_DEC, V_WR_OPND_DN};
      issue(OP_PUSH, 4'h0, 16'hFFE0);
      wait_idle();
      chk("push_sp", {48'd0, sp}, 64'h03FE);

      set_sp(16'h0400);
      plan = '{V_DEC, V_WR_PC, V_DEC, V_WR_SR, V_VEC_DN};
      issue(OP_INT, 4'hA, 16'hFFF4);
      wait_idle();
      chk("int_sp", {48'd0, sp}, 64'h03FC);
      chk("vec_hold", {48'd0, bus.vec_addr}, 64'hFFF4);

      plan = '{V_RD_SR, V_INC, V_RD_PC, V_INC_DN};
      issue(OP_RETI, 4'h0, 16'hFFE0);
      wait_idle();
      chk("reti_sp", {48'd0, sp}, 64'h0400);

      plan = '{V_DEC, V_WR_PC_DN};
      issue(OP_CALL, 4'h5, 16'hFFEA);
      wait_idle();
      chk("call_sp", {48'd0, sp}, 64'h03FE);

      plan = '{V_RD_PC_DN, V_INC_DN};
      plan[0] = V_RD_PC;
      issue(OP_RET, 4'h0, 16'hFFE0);
      wait_idle();
      chk("ret_sp", {48'd0, sp}, 64'h0400);

      // Exactly at the limit after decrement: legal.
      set_sp(16'h0202);
      plan = '{V_DEC, V_WR_OPND_DN};
      issue(OP_PUSH, 4'h0, 16'hFFE0);
      wait_idle();
      chk("push_edge_sp", {48'd0, sp}, 64'h0200);

      plan = '{V_FAULT};
      issue(OP_PUSH, 4'h0, 16'hFFE0);
      wait_idle();
      chk("underflow_sp", {48'd0, sp}, 64'h0200);
      chk("underflow_ready", {63'd0, bus.op_ready}, 64'd1);

      set_sp(16'h0000);
      plan = '{V_FAULT};
      issue(OP_PUSH, 4'h0, 16'hFFE0);
      wait_idle();
      chk("zero_sp", {48'd0, sp}, 64'h0000);

      set_sp(16'h0202);
      plan = '{V_DEC, V_WR_PC, V_FAULT};
      issue(OP_INT, 4'h3, 16'hFFE6);
      wait_idle();
      chk("int_fault_sp", {48'd0, sp}, 64'h0200);

      // Illegal op, with a PUSH held on op_valid while the sequencer is busy.
      set_sp(16'h0400);
      plan = '{V_FAULT};
      issue(3'd6, 4'h0, 16'hFFE0);
      a = last_acc;
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_code  = OP_PUSH;
      bus.int_idx  = 4'h1;
      chk("busy_not_ready", {63'd0, bus.op_ready}, 64'd0);
      exp_q.push_back({a + 32'd2, V_DEC, 16'hFFE2});
      exp_q.push_back({a + 32'd3, V_WR_OPND_DN, 16'hFFE2});
      repeat (2) @(posedge clk);
      #1 bus.op_valid = 1'b0;
      wait_idle();
      chk("held_push_sp", {48'd0, sp}, 64'h03FE);

      // Reset during the second DEC of an interrupt entry.
      set_sp(16'h0400);
      plan = '{V_DEC, V_WR_PC, V_DEC};
      issue(OP_INT, 4'h2, 16'hFFE4);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {36'd0, obs, bus.vec_addr}, 64'd0);
      chk("abort_ready", {63'd0, bus.op_ready}, 64'd1);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_sp", {48'd0, sp}, 64'h03FE);
      chk("abort_idle", {63'd0, bus.op_ready}, 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
